// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi
// Multi-channel servo PWM generator. All channels share one period counter.
// Positions written through the write port become targets. Targets are
// folded into the live pulse widths only at period boundaries, so a pulse is
// never truncated or stretched mid-period. An optional slew limit moves each
// channel's current position toward its target by at most STEP per period.

module servo_pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int POS_W    = 8,
    parameter int CNT_W    = 14,
    parameter int PERIOD   = 10000,
    parameter int SCALE    = 39,
    parameter int OFFSET   = 0,
    parameter int STEP     = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [POS_W-1:0]    wr_pos,
    input  logic [CHANNELS-1:0] ch_en,
    output logic                wr_ack,
    output logic                period_start,
    output logic [CHANNELS-1:0] settled,
    output logic [CHANNELS-1:0] pwm_out
);

    // Width math is done wide enough that OFFSET + pos*SCALE cannot wrap
    // before it is saturated back down to one full period.
    localparam int WW = CNT_W + POS_W;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(PERIOD);
    localparam logic [WW-1:0]    PERIOD_W   = WW'(PERIOD);
    localparam logic [WW-1:0]    SCALE_W    = WW'(SCALE);
    localparam logic [WW-1:0]    OFFSET_W   = WW'(OFFSET);

    // A step larger than the whole position range behaves like "jump
    // directly", so it is clamped to the largest representable position.
    localparam int               POS_MAX = (1 << POS_W) - 1;
    localparam int               STEP_C  = (STEP > POS_MAX) ? POS_MAX : STEP;
    localparam logic [POS_W-1:0] STEP_V  = POS_W'(STEP_C);

    // One extra bit so that a non-power-of-two channel count can reject the
    // unused upper indices of wr_ch.
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

    logic [CNT_W-1:0] counter;
    logic             boundary;
    logic             wr_valid;

    logic [POS_W-1:0] target     [CHANNELS];
    logic [POS_W-1:0] cur_pos    [CHANNELS];
    logic [POS_W-1:0] next_cur   [CHANNELS];
    logic [WW-1:0]    raw_width  [CHANNELS];
    logic [CNT_W-1:0] next_width [CHANNELS];
    logic [CNT_W-1:0] width      [CHANNELS];

    assign boundary = (counter == LAST_CNT);
    assign wr_valid = wr_en && ({1'b0, wr_ch} < CH_LIM);

    // Shared period counter, 0..PERIOD-1, wrapping on the boundary edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (boundary) begin
            counter <= '0;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    // One-cycle status pulses: boundary marker and write acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start <= 1'b0;
            wr_ack       <= 1'b0;
        end else begin
            period_start <= boundary;
            wr_ack       <= wr_valid;
        end
    end

    // Target registers; a write on a boundary edge lands after the boundary
    // has already sampled the old target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
            end
        end else if (wr_valid) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_ch == CH_W'(i)) begin
                    target[i] <= wr_pos;
                end
            end
        end
    end

    // Next current position: jump to target, or approach it by at most STEP.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            next_cur[i] = cur_pos[i];
            if (STEP == 0) begin
                next_cur[i] = target[i];
            end else if (target[i] > cur_pos[i]) begin
                if ((target[i] - cur_pos[i]) > STEP_V) begin
                    next_cur[i] = cur_pos[i] + STEP_V;
                end else begin
                    next_cur[i] = target[i];
                end
            end else if (target[i] < cur_pos[i]) begin
                if ((cur_pos[i] - target[i]) > STEP_V) begin
                    next_cur[i] = cur_pos[i] - STEP_V;
                end else begin
                    next_cur[i] = target[i];
                end
            end
        end
    end

    // Pulse width for the coming period, saturated to a full period.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            raw_width[i] = OFFSET_W + ({{CNT_W{1'b0}}, next_cur[i]} * SCALE_W);
            if (raw_width[i] > PERIOD_W) begin
                next_width[i] = PERIOD_CNT;
            end else begin
                next_width[i] = raw_width[i][CNT_W-1:0];
            end
        end
    end

    // Position and width registers only change on the boundary edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cur_pos[i] <= '0;
                width[i]   <= '0;
            end
        end else if (boundary) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cur_pos[i] <= next_cur[i];
                width[i]   <= next_width[i];
            end
        end
    end

    // Registered PWM compare, so outputs lag the counter by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= ch_en[i] && (counter < width[i]);
            end
        end
    end

    // A channel is settled once its current position has reached its target.
    always_comb begin
        settled = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            settled[i] = (cur_pos[i] == target[i]);
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi
// Two instances: one with default parameters (direct jumps, 10000-cycle
// period) and a short-period slew-limited one with a non-power-of-two
// channel count, so out-of-range writes and saturation are reachable quickly.

module tb_servo_pwm_multi;

    localparam int A_CH     = 4;
    localparam int A_PERIOD = 10000;
    localparam int A_SCALE  = 39;

    localparam int B_CH     = 3;
    localparam int B_PERIOD = 400;
    localparam int B_SCALE  = 2;
    localparam int B_OFFSET = 100;
    localparam int B_STEP   = 10;

    typedef struct {
        int ch;
        int pos;
        bit ack;
    } wr_vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    logic        a_wr_en;
    logic [1:0]  a_wr_ch;
    logic [7:0]  a_wr_pos;
    logic [3:0]  a_ch_en;
    logic        a_wr_ack;
    logic        a_period_start;
    logic [3:0]  a_settled;
    logic [3:0]  a_pwm_out;

    logic        b_wr_en;
    logic [1:0]  b_wr_ch;
    logic [7:0]  b_wr_pos;
    logic [2:0]  b_ch_en;
    logic        b_wr_ack;
    logic        b_period_start;
    logic [2:0]  b_settled;
    logic [2:0]  b_pwm_out;

    int checks = 0;
    int errors = 0;

    bit ack_q_a[$];
    bit ack_q_b[$];

    int a_tgt [A_CH];
    int b_tgt [B_CH];
    int b_cur [B_CH];
    int a_hi  [A_CH];
    int b_hi  [B_CH];
    int exp_hi_b [B_CH];
    int ps_idx;

    wr_vec_t a_tbl [4];
    wr_vec_t b_tbl [5];

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    servo_pwm_multi u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .wr_en        (a_wr_en),
        .wr_ch        (a_wr_ch),
        .wr_pos       (a_wr_pos),
        .ch_en        (a_ch_en),
        .wr_ack       (a_wr_ack),
        .period_start (a_period_start),
        .settled      (a_settled),
        .pwm_out      (a_pwm_out)
    );

    servo_pwm_multi #(
        .CHANNELS (3),
        .POS_W    (8),
        .CNT_W    (9),
        .PERIOD   (400),
        .SCALE    (2),
        .OFFSET   (100),
        .STEP     (10)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .wr_en        (b_wr_en),
        .wr_ch        (b_wr_ch),
        .wr_pos       (b_wr_pos),
        .ch_en        (b_ch_en),
        .wr_ack       (b_wr_ack),
        .period_start (b_period_start),
        .settled      (b_settled),
        .pwm_out      (b_pwm_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int widthA(input int pos);
        int w;
        w = pos * A_SCALE;
        return (w > A_PERIOD) ? A_PERIOD : w;
    endfunction

    function automatic int widthB(input int pos);
        int w;
        w = B_OFFSET + pos * B_SCALE;
        return (w > B_PERIOD) ? B_PERIOD : w;
    endfunction

    task automatic modelBoundaryB();
        for (int c = 0; c < B_CH; c++) begin
            if (b_tgt[c] > b_cur[c]) begin
                b_cur[c] = (b_tgt[c] - b_cur[c] > B_STEP) ? b_cur[c] + B_STEP : b_tgt[c];
            end else if (b_tgt[c] < b_cur[c]) begin
                b_cur[c] = (b_cur[c] - b_tgt[c] > B_STEP) ? b_cur[c] - B_STEP : b_tgt[c];
            end
        end
    endtask

    function automatic logic [2:0] settledB();
        logic [2:0] s;
        for (int c = 0; c < B_CH; c++) begin
            s[c] = (b_cur[c] == b_tgt[c]);
        end
        return s;
    endfunction

    task automatic popAckA();
        if (ack_q_a.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL a_ack_queue: got empty, expected an entry");
        end else begin
            checkOutput("a_wr_ack", a_wr_ack, ack_q_a.pop_front());
        end
    endtask

    task automatic popAckB();
        if (ack_q_b.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL b_ack_queue: got empty, expected an entry");
        end else begin
            checkOutput("b_wr_ack", b_wr_ack, ack_q_b.pop_front());
        end
    endtask

    task automatic applyStimulusA(input wr_vec_t v);
        a_wr_en  = 1'b1;
        a_wr_ch  = v.ch[1:0];
        a_wr_pos = v.pos[7:0];
        ack_q_a.push_back(v.ack);
        @(negedge clk);
        a_wr_en = 1'b0;
        popAckA();
        if (v.ack) a_tgt[v.ch] = v.pos;
    endtask

    task automatic applyStimulusB(input wr_vec_t v);
        b_wr_en  = 1'b1;
        b_wr_ch  = v.ch[1:0];
        b_wr_pos = v.pos[7:0];
        ack_q_b.push_back(v.ack);
        @(negedge clk);
        b_wr_en = 1'b0;
        popAckB();
        if (v.ack) b_tgt[v.ch] = v.pos;
    endtask

    task automatic waitBoundaryA(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (a_period_start) seen = 1'b1;
        end
        checkOutput("a_boundary_seen", seen, 1);
    endtask

    task automatic waitBoundaryB(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (b_period_start) seen = 1'b1;
        end
        checkOutput("b_boundary_seen", seen, 1);
    endtask

    // Sample j of a period reflects counter value j; optional write at wr_j.
    task automatic runPeriodB(input int wr_j, input int wr_ch, input int wr_pos, input bit wr_exp);
        bit pend = 1'b0;
        for (int c = 0; c < B_CH; c++) b_hi[c] = 0;
        ps_idx = -1;
        for (int j = 0; j < B_PERIOD; j++) begin
            @(negedge clk);
            for (int c = 0; c < B_CH; c++) begin
                if (b_pwm_out[c]) b_hi[c]++;
            end
            if (b_period_start && ps_idx < 0) ps_idx = j;
            if (pend) begin
                popAckB();
                b_wr_en = 1'b0;
                pend = 1'b0;
            end
            if (j == wr_j) begin
                b_wr_en  = 1'b1;
                b_wr_ch  = wr_ch[1:0];
                b_wr_pos = wr_pos[7:0];
                ack_q_b.push_back(wr_exp);
                pend = 1'b1;
            end
        end
    endtask

    // Measures one default-instance period, optionally gating ch_en[3].
    task automatic runPeriodA(input int dis0, input int dis1);
        for (int c = 0; c < A_CH; c++) a_hi[c] = 0;
        ps_idx = -1;
        for (int j = 0; j < A_PERIOD; j++) begin
            @(negedge clk);
            for (int c = 0; c < A_CH; c++) begin
                if (a_pwm_out[c]) a_hi[c]++;
            end
            if (a_period_start && ps_idx < 0) ps_idx = j;
            if (j == dis0) checkOutput("a_pwm3_disabled", a_pwm_out[3], 0);
            if (j == dis1) checkOutput("a_pwm3_resumed", a_pwm_out[3], 1);
            if (j == dis0 - 1) a_ch_en[3] = 1'b0;
            if (j == dis1 - 1) a_ch_en[3] = 1'b1;
        end
    endtask

    initial begin
        int pend_ch;
        int pend_pos;
        int hi_any;
        logic [3:0] exp_set_a;

        a_tbl[0] = '{ch: 1, pos: 77,  ack: 1'b1};
        a_tbl[1] = '{ch: 0, pos: 128, ack: 1'b1};
        a_tbl[2] = '{ch: 3, pos: 255, ack: 1'b1};
        a_tbl[3] = '{ch: 1, pos: 0,   ack: 1'b1};

        b_tbl[0] = '{ch: 0, pos: 255, ack: 1'b1};
        b_tbl[1] = '{ch: 3, pos: 77,  ack: 1'b0};
        b_tbl[2] = '{ch: 1, pos: 90,  ack: 1'b1};
        b_tbl[3] = '{ch: 1, pos: 35,  ack: 1'b1};
        b_tbl[4] = '{ch: 2, pos: 0,   ack: 1'b1};

        for (int c = 0; c < A_CH; c++) a_tgt[c] = 0;
        for (int c = 0; c < B_CH; c++) begin
            b_tgt[c] = 0;
            b_cur[c] = 0;
        end

        a_wr_en = 1'b0; a_wr_ch = '0; a_wr_pos = '0; a_ch_en = '0;
        b_wr_en = 1'b0; b_wr_ch = '0; b_wr_pos = '0; b_ch_en = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        checkOutput("a_reset_pwm", a_pwm_out, 0);
        checkOutput("a_reset_ack", a_wr_ack, 0);
        checkOutput("a_reset_ps", a_period_start, 0);
        checkOutput("a_reset_settled", a_settled, 4'hF);
        checkOutput("b_reset_pwm", b_pwm_out, 0);
        checkOutput("b_reset_settled", b_settled, 3'h7);

        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_ch_en = 4'hF;
        b_ch_en = 3'h7;

        $display("[TB] slew-limited instance: table writes");
        for (int k = 0; k < 5; k++) applyStimulusB(b_tbl[k]);
        checkOutput("b_settled_pre", b_settled, settledB());
        waitBoundaryB(2 * B_PERIOD);

        pend_ch = -1;
        pend_pos = 0;
        for (int p = 1; p <= 27; p++) begin
            modelBoundaryB();
            if (pend_ch >= 0) begin
                b_tgt[pend_ch] = pend_pos;
                pend_ch = -1;
            end
            checkOutput($sformatf("b_settled_p%0d", p), b_settled, settledB());
            for (int c = 0; c < B_CH; c++) exp_hi_b[c] = widthB(b_cur[c]);
            if (p == 5) begin
                runPeriodB(B_PERIOD - 2, 2, 50, 1'b1);
                pend_ch = 2;
                pend_pos = 50;
            end else if (p == 6) begin
                runPeriodB(10, 3, 200, 1'b0);
            end else begin
                runPeriodB(-1, 0, 0, 1'b0);
            end
            for (int c = 0; c < B_CH; c++) begin
                checkOutput($sformatf("b_high_ch%0d_p%0d", c, p), b_hi[c], exp_hi_b[c]);
            end
            checkOutput($sformatf("b_period_len_p%0d", p), ps_idx, B_PERIOD - 1);
        end

        $display("[TB] default instance: table writes");
        for (int k = 0; k < 4; k++) applyStimulusA(a_tbl[k]);
        for (int c = 0; c < A_CH; c++) exp_set_a[c] = (a_tgt[c] == 0);
        checkOutput("a_settled_pre", a_settled, exp_set_a);
        waitBoundaryA(2 * A_PERIOD);
        checkOutput("a_settled_post", a_settled, 4'hF);

        runPeriodA(-1, -1);
        for (int c = 0; c < A_CH; c++) begin
            checkOutput($sformatf("a_high_ch%0d", c), a_hi[c], widthA(a_tgt[c]));
        end
        checkOutput("a_period_len", ps_idx, A_PERIOD - 1);

        $display("[TB] default instance: ch_en[3] gap");
        runPeriodA(200, 300);
        checkOutput("a_high_ch0_gap", a_hi[0], widthA(a_tgt[0]));
        checkOutput("a_high_ch3_gap", a_hi[3], widthA(a_tgt[3]) - 100);
        checkOutput("a_period_len_gap", ps_idx, A_PERIOD - 1);

        $display("[TB] default instance: reset mid-pulse");
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (j == 298) begin
                a_wr_en  = 1'b1;
                a_wr_ch  = 2'd2;
                a_wr_pos = 8'd9;
                ack_q_a.push_back(1'b1);
            end
            if (j == 299) begin
                popAckA();
                a_wr_en = 1'b0;
                checkOutput("a_pwm0_before_reset", a_pwm_out[0], 1);
                checkOutput("a_counter_before_reset", u_dut_a.counter, 300);
            end
        end
        #2;
        rst_a = 1'b1;
        #1;
        checkOutput("a_async_pwm", a_pwm_out, 0);
        checkOutput("a_async_ack", a_wr_ack, 0);
        checkOutput("a_async_ps", a_period_start, 0);
        checkOutput("a_async_settled", a_settled, 4'hF);
        checkOutput("a_async_counter", u_dut_a.counter, 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;

        hi_any = 0;
        ps_idx = -1;
        for (int j = 0; j < A_PERIOD + 100; j++) begin
            @(negedge clk);
            if (a_pwm_out != 4'h0) hi_any++;
            if (a_period_start && ps_idx < 0) ps_idx = j;
        end
        checkOutput("a_pwm_after_reset", hi_any, 0);
        checkOutput("a_first_boundary_after_reset", ps_idx, A_PERIOD - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel servo PWM generator and parametrised successor to the single-channel 8-bit servo PWM. All channels share one period counter. Each channel holds a target position written over a simple write port, plus an optional slew-limited current position. Duty changes take effect only at period boundaries, so no channel ever emits a truncated or glitched pulse. The block sits between the position-command logic (keypad/UART decoders) and the servo output pins.

Parameters:
CHANNELS, 4, number of independent PWM outputs (1..16)
POS_W, 8, width of a position command
CNT_W, 14, width of the shared period counter
PERIOD, 10000, counter cycles per PWM period (must be < 2^CNT_W)
SCALE, 39, clock cycles of high time per position LSB
OFFSET, 0, fixed high-time cycles added to every pulse (minimum pulse)
STEP, 0, maximum position change per period; 0 = no slew limit (jump directly)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write strobe for target position, single-cycle qualified
wr_ch  in  clog2(CHANNELS) (min 1)  channel index of the write
wr_pos  in  POS_W  new target position
ch_en  in  CHANNELS  per-channel output enable; low forces that output to 0
wr_ack  out  1  one-cycle pulse the cycle after an accepted write
period_start  out  1  one-cycle pulse the cycle after the counter wraps to 0
settled  out  CHANNELS  bit i high when cur_pos[i] == target[i]
pwm_out  out  CHANNELS  PWM outputs

Behaviour:
- Reset (asynchronous, immediate):
  - counter=0; all target, cur_pos and width registers 0.
  - pwm_out=0, wr_ack=0, period_start=0, settled=all 1.
  - Reset mid-period truncates pulses immediately. After release, counting restarts at 0.
- Counter:
  - Increments every clk and runs 0..PERIOD-1.
  - At counter==PERIOD-1 the next value is 0. This edge is the "boundary".
  - period_start is registered high for exactly one cycle following each boundary edge.
  - No boundary pulse is generated on reset release.
- Write port:
  - wr_en=1 with wr_ch<CHANNELS sets target[wr_ch]=wr_pos at that edge; wr_ack=1 next cycle.
  - wr_ch>=CHANNELS: write ignored, no wr_ack.
  - Back-to-back writes are allowed every cycle; the last write to a channel before a boundary wins.
  - Write on the same edge as a boundary: the boundary uses the pre-write target. The new target applies at the next boundary.
- Boundary update, per channel i, all at the same edge:
  - STEP==0: cur_pos <= target.
  - STEP>0: cur_pos moves toward target by min(STEP, |target-cur_pos|). No overshoot, no wrap; unsigned compare.
  - width[i] <= OFFSET + next_cur_pos*SCALE, computed at CNT_W+POS_W bits and saturated to PERIOD.
- Output:
  - Registered: pwm_out[i] at edge k+1 = ch_en[i] && (counter_k < width[i]).
  - High time is exactly width[i] cycles per period, lagging the counter by 1 cycle.
  - width==0 gives constant low. width==PERIOD gives constant high.
  - ch_en toggles take effect on the next edge, even mid-period.
- Latency: a write reaches its output at the first boundary after the write edge. The new pulse starts one cycle after that boundary.
- settled: combinational compare of registered values; it changes only on a write or a boundary.

Test Plan:
- Defaults, reset then write ch0=128 → wr_ack 1 cycle later; after the first boundary, pwm_out[0] is high exactly 4992 cycles of every 10000. Other channels stay low.
- Write pos=255 with SCALE=39 → width 9945. Then OFFSET=100, pos=255 → width 10045 saturates to 10000, so output is constant high.
- STEP=10, write ch1 from 0 to 35 → cur_pos goes 10, 20, 30, 35 over four boundaries. settled[1] is low until the fourth boundary and high after it.
- Writes on the same edge as the boundary (ch2=50), then wr_ch=CHANNELS (out-of-range) → ch2 changes only at the following boundary; the out-of-range write gives no wr_ack and no state change.
- Assert rst mid-pulse at counter=300 with pwm_out high → pwm_out, wr_ack and counter go to 0 asynchronously, before the next edge. After release, no output until new writes plus a boundary.
- Drop ch_en[3] mid-pulse, then raise it again → output goes low next edge and resumes the correct width; the period and counter are unaffected.
